// File: rtl/im_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : im_fetch_seq
// Purpose  : Reads the boot-loaded instruction image back in address order and
//            streams it to the pipeline front end over a valid/ready handshake.
// Revision : 1.0 - initial release
// ============================================================================
module im_fetch_seq #(
  parameter int ADDR_W    = 32,
  parameter int DATA_W    = 32,
  parameter int BUF_DEPTH = 2
) (
  input  logic              clk,
  input  logic              RSTcount,
  input  logic              PCstart,
  input  logic              load_done,
  input  logic [ADDR_W-1:0] load_count,
  input  logic              redirect_valid,
  input  logic [ADDR_W-1:0] redirect_target,
  output logic              rd_en,
  output logic [ADDR_W-1:0] rd_addr,
  input  logic [DATA_W-1:0] rdata,
  output logic              instr_valid,
  input  logic              instr_ready,
  output logic [DATA_W-1:0] instr,
  output logic [ADDR_W-1:0] instr_pc,
  output logic              busy,
  output logic              done
);

  localparam int PTR_W = $clog2(BUF_DEPTH);
  localparam int CNT_W = PTR_W + 1;

  localparam logic [1:0] c_IDLE  = 2'd0;
  localparam logic [1:0] c_FETCH = 2'd1;
  localparam logic [1:0] c_DRAIN = 2'd2;
  localparam logic [1:0] c_DONE  = 2'd3;

  logic [1:0]        state_q, state_d;
  logic [ADDR_W-1:0] pc_q, pc_d;
  logic [ADDR_W-1:0] limit_q, limit_d;
  logic [ADDR_W-1:0] raddr_q;
  logic              inflight_q, inflight_d;
  logic [PTR_W-1:0]  wptr_q, rptr_q;
  logic [CNT_W-1:0]  count_q, count_d;
  logic [DATA_W-1:0] buf_data_q [BUF_DEPTH];
  logic [ADDR_W-1:0] buf_pc_q   [BUF_DEPTH];

  logic active, start, redir, issue, push, pop, empty;

  assign active = (state_q == c_FETCH) || (state_q == c_DRAIN);
  assign start  = load_done && PCstart && (load_count != '0);
  assign redir  = active && redirect_valid;
  assign empty  = (count_q == '0);
  // Buffered words plus the one in flight must never exceed the buffer size.
  assign issue  = (state_q == c_FETCH) && !redirect_valid && (pc_q < limit_q) &&
                  ((count_q + CNT_W'(inflight_q)) < CNT_W'(BUF_DEPTH));
  assign push   = inflight_q && !redir;
  assign pop    = !empty && instr_ready && !redir;

  always_comb begin
    pc_d       = pc_q;
    limit_d    = limit_q;
    inflight_d = issue;
    count_d    = count_q;
    if ((state_q == c_IDLE) && start) begin
      pc_d    = '0;
      limit_d = load_count;
    end
    if (redir) begin
      pc_d    = redirect_target;
      count_d = '0;
    end else begin
      if (issue) pc_d = pc_q + ADDR_W'(1);
      case ({push, pop})
        2'b10:   count_d = count_q + CNT_W'(1);
        2'b01:   count_d = count_q - CNT_W'(1);
        default: count_d = count_q;
      endcase
    end
  end

  always_ff @(posedge clk or posedge RSTcount) begin
    if (RSTcount) begin
      pc_q       <= '0;
      limit_q    <= '0;
      raddr_q    <= '0;
      inflight_q <= 1'b0;
      wptr_q     <= '0;
      rptr_q     <= '0;
      count_q    <= '0;
    end else begin
      pc_q       <= pc_d;
      limit_q    <= limit_d;
      inflight_q <= inflight_d;
      count_q    <= count_d;
      if (issue) raddr_q <= pc_q;
      if (redir) begin
        wptr_q <= '0;
        rptr_q <= '0;
      end else begin
        if (push) wptr_q <= wptr_q + PTR_W'(1);
        if (pop)  rptr_q <= rptr_q + PTR_W'(1);
      end
    end
  end

  always_ff @(posedge clk) begin
    if (push) begin
      buf_data_q[wptr_q] <= rdata;
      buf_pc_q[wptr_q]   <= raddr_q;
    end
  end

  always_ff @(posedge clk or posedge RSTcount) begin
    if (RSTcount) state_q <= c_IDLE;
    else          state_q <= state_d;
  end

  // Completion is judged on next-cycle occupancy so done follows the last pop directly.
  always_comb begin
    state_d = state_q;
    case (state_q)
      c_IDLE: if (start) state_d = c_FETCH;
      c_FETCH, c_DRAIN: begin
        if (redir) begin
          state_d = (redirect_target >= limit_q) ? c_DRAIN : c_FETCH;
        end else if (pc_d >= limit_q) begin
          state_d = (inflight_d || (count_d != '0)) ? c_DRAIN : c_DONE;
        end
      end
      default: state_d = c_DONE;
    endcase
  end

  always_comb begin
    rd_en       = issue;
    rd_addr     = issue ? pc_q : '0;
    instr_valid = !empty;
    instr       = empty ? '0 : buf_data_q[rptr_q];
    instr_pc    = empty ? '0 : buf_pc_q[rptr_q];
    busy        = active;
    done        = (state_q == c_DONE);
  end

endmodule
`default_nettype wire

// File: tb/tb_im_fetch_seq.sv
`default_nettype none
// ============================================================================
// Module   : tb_im_fetch_seq
// Purpose  : Randomized and directed self-checking bench for im_fetch_seq.
// Revision : 1.0 - initial release
// ============================================================================
module tb_im_fetch_seq;

  localparam int ADDR_W    = 32;
  localparam int DATA_W    = 32;
  localparam int BUF_DEPTH = 2;

  logic              clk = 1'b0;
  logic              RSTcount;
  logic              PCstart, load_done;
  logic [ADDR_W-1:0] load_count;
  logic              redirect_valid;
  logic [ADDR_W-1:0] redirect_target;
  logic              rd_en;
  logic [ADDR_W-1:0] rd_addr;
  logic [DATA_W-1:0] rdata;
  logic              instr_valid, instr_ready;
  logic [DATA_W-1:0] instr;
  logic [ADDR_W-1:0] instr_pc;
  logic              busy, done;

  im_fetch_seq #(.ADDR_W(ADDR_W), .DATA_W(DATA_W), .BUF_DEPTH(BUF_DEPTH)) dut (
    .clk(clk), .RSTcount(RSTcount), .PCstart(PCstart), .load_done(load_done),
    .load_count(load_count), .redirect_valid(redirect_valid),
    .redirect_target(redirect_target), .rd_en(rd_en), .rd_addr(rd_addr),
    .rdata(rdata), .instr_valid(instr_valid), .instr_ready(instr_ready),
    .instr(instr), .instr_pc(instr_pc), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int n_cmp  = 0;
  int n_fail = 0;
  int cyc    = 0;

  // Reference model: phase 0 idle, 1 fetching, 2 draining, 3 finished.
  int          m_st;
  logic [31:0] m_pc, m_limit, m_fly_addr;
  bit          m_fly;
  logic [31:0] m_q[$];

  // Stimulus controls.
  bit          g_ld;
  logic [31:0] g_cnt;
  int          ready_mode;
  bit          redir_rand, redir_arm, redir_seen, rel_reset;
  logic [31:0] redir_at, redir_tgt;
  bit          ret_v;
  logic [31:0] ret_a;

  // Observation logs.
  logic [31:0] issued[$];
  logic [31:0] delivered[$];
  int          first_rd, first_val, rd_after_redir, max_out;
  bit          s_valid, s_busy, s_done;
  logic [31:0] s_pc;

  function automatic logic [31:0] memf(input logic [31:0] a);
    return (a * 32'h9E37_79B1) ^ 32'hC0DE_0000;
  endfunction

  task automatic chk(input string nm, input logic [31:0] got, input logic [31:0] want);
    n_cmp++;
    if (got !== want) begin
      n_fail++;
      $display("FAIL %s: got %0h, expected %0h", nm, got, want);
    end
  endtask

  function automatic bit exp_issue();
    return (m_st == 1) && !redirect_valid && (m_pc < m_limit) &&
           ((m_q.size() + int'(m_fly)) < BUF_DEPTH);
  endfunction

  task automatic model_reset();
    m_st = 0; m_pc = 0; m_limit = 0; m_fly = 0; m_fly_addr = 0;
    m_q.delete();
  endtask

  task automatic model_update();
    bit iss;
    bit act;
    iss = exp_issue();
    act = (m_st == 1) || (m_st == 2);
    if (m_st == 0) begin
      if (load_done && PCstart && load_count != 0) begin
        m_st = 1; m_pc = 0; m_limit = load_count;
      end
    end else if (act && redirect_valid) begin
      m_q.delete();
      m_fly = 0;
      m_pc  = redirect_target;
      m_st  = (redirect_target >= m_limit) ? 2 : 1;
    end else if (act) begin
      if (m_q.size() > 0 && instr_ready) void'(m_q.pop_front());
      if (m_fly) m_q.push_back(m_fly_addr);
      m_fly      = iss;
      m_fly_addr = m_pc;
      if (iss) m_pc = m_pc + 1;
      if (m_pc >= m_limit) m_st = (m_fly || m_q.size() > 0) ? 2 : 3;
    end
  endtask

  task automatic check_cycle();
    logic              e_rd, e_v, e_busy, e_done;
    logic [31:0]       e_addr, e_pc, e_instr;
    e_rd    = exp_issue();
    e_addr  = e_rd ? m_pc : 32'd0;
    e_v     = (m_q.size() > 0);
    e_pc    = e_v ? m_q[0] : 32'd0;
    e_instr = e_v ? memf(m_q[0]) : 32'd0;
    e_busy  = (m_st == 1) || (m_st == 2);
    e_done  = (m_st == 3);
    n_cmp++;
    if ({rd_en, rd_addr, instr_valid, instr, instr_pc, busy, done} !==
        {e_rd, e_addr, e_v, e_instr, e_pc, e_busy, e_done}) begin
      n_fail++;
      $display("FAIL cycle %0d outputs: got rd_en=%b rd_addr=%0h valid=%b instr=%0h pc=%0h busy=%b done=%b, expected rd_en=%b rd_addr=%0h valid=%b instr=%0h pc=%0h busy=%b done=%b",
               cyc, rd_en, rd_addr, instr_valid, instr, instr_pc, busy, done,
               e_rd, e_addr, e_v, e_instr, e_pc, e_busy, e_done);
    end
  endtask

  task automatic step();
    @(negedge clk);
    cyc++;
    if (rel_reset) begin RSTcount = 1'b0; rel_reset = 1'b0; end
    load_done  = g_ld;
    PCstart    = g_ld;
    load_count = g_cnt;
    rdata      = ret_v ? memf(ret_a) : $urandom;
    case (ready_mode)
      0:       instr_ready = 1'b1;
      1:       instr_ready = 1'b0;
      default: instr_ready = ($urandom_range(0, 3) != 0);
    endcase
    redirect_valid  = 1'b0;
    redirect_target = $urandom;
    if (m_st == 1 || m_st == 2) begin
      if (redir_rand) begin
        if ($urandom_range(0, 11) == 0) begin
          redirect_valid  = 1'b1;
          redirect_target = $urandom_range(0, m_limit + 2);
        end
      end else if (redir_arm && m_fly && m_fly_addr == redir_at) begin
        redirect_valid  = 1'b1;
        redirect_target = redir_tgt;
        redir_arm       = 1'b0;
        redir_seen      = 1'b1;
      end
    end
    #1;
    check_cycle();
    if (rd_en) begin
      issued.push_back(rd_addr);
      if (first_rd < 0) first_rd = cyc;
      if (redir_seen) rd_after_redir++;
    end
    if (instr_valid && first_val < 0) first_val = cyc;
    if (instr_valid && instr_ready && !redirect_valid) delivered.push_back(instr_pc);
    if (issued.size() - delivered.size() > max_out) max_out = issued.size() - delivered.size();
    s_valid = instr_valid; s_busy = busy; s_done = done; s_pc = instr_pc;
    ret_v = rd_en;
    ret_a = rd_addr;
    @(posedge clk);
    model_update();
  endtask

  task automatic clear_logs();
    issued.delete(); delivered.delete();
    first_rd = -1; first_val = -1; rd_after_redir = 0; max_out = 0;
    redir_seen = 0; redir_arm = 0; redir_rand = 0;
  endtask

  // Async reset, held across one rising edge; released by the next step.
  task automatic apply_reset();
    RSTcount = 1'b1;
    g_ld = 0; load_done = 0; PCstart = 0; redirect_valid = 0;
    model_reset();
    ret_v = 0;
    @(posedge clk);
    rel_reset = 1'b1;
  endtask

  task automatic begin_run(input logic [31:0] cnt);
    clear_logs();
    g_cnt = cnt;
    g_ld  = 1;
  endtask

  task automatic run_to_done(input int budget);
    int n;
    n = 0;
    while (m_st != 3 && n < budget) begin step(); n++; end
    if (m_st != 3) chk("run_budget_expired", 32'd1, 32'd0);
    step();
    chk("done_sticky", {31'd0, s_done}, 32'd1);
  endtask

  task automatic chk_seq(input string nm, input int first, input int n);
    chk({nm, "_len"}, delivered.size(), n);
    for (int i = 0; i < n && i < delivered.size(); i++)
      chk(nm, delivered[i], first + i);
  endtask

  initial begin
    int bad;
    RSTcount = 1'b1; g_ld = 0; g_cnt = 0; ready_mode = 0; rel_reset = 0;
    load_done = 0; PCstart = 0; load_count = 0; redirect_valid = 0;
    redirect_target = 0; rdata = 0; instr_ready = 0; ret_v = 0; ret_a = 0;
    model_reset(); clear_logs();
    #1;
    chk("reset_rd_en", {31'd0, rd_en}, 32'd0);
    chk("reset_rd_addr", rd_addr, 32'd0);
    chk("reset_valid", {31'd0, instr_valid}, 32'd0);
    chk("reset_instr", instr, 32'd0);
    chk("reset_busy_done", {30'd0, busy, done}, 32'd0);
    @(posedge clk);
    rel_reset = 1'b1;

    // Basic stream of four words.
    ready_mode = 0;
    begin_run(4);
    run_to_done(100);
    chk("basic_issued_len", issued.size(), 4);
    for (int i = 0; i < 4 && i < issued.size(); i++) chk("basic_rd_addr", issued[i], i);
    chk_seq("basic_delivered", 0, 4);
    chk("basic_first_latency", first_val - first_rd, 2);

    // Backpressure for five cycles.
    apply_reset();
    ready_mode = 1;
    begin_run(6);
    repeat (6) step();
    chk("bp_stalled_valid", {31'd0, s_valid}, 32'd1);
    chk("bp_stalled_pc", s_pc, 32'd0);
    ready_mode = 0;
    run_to_done(200);
    chk("bp_max_outstanding", max_out, BUF_DEPTH);
    chk_seq("bp_delivered", 0, 6);

    // Redirect to 5 while word 2 is in flight.
    apply_reset();
    ready_mode = 0;
    begin_run(8);
    redir_arm = 1; redir_at = 2; redir_tgt = 5;
    run_to_done(200);
    chk("redir_len", delivered.size(), 5);
    if (delivered.size() == 5) begin
      chk("redir_d0", delivered[0], 0);
      chk("redir_d1", delivered[1], 1);
      chk("redir_d2", delivered[2], 5);
      chk("redir_d3", delivered[3], 6);
      chk("redir_d4", delivered[4], 7);
    end

    // Redirect beyond the image while word 3 is in flight.
    apply_reset();
    begin_run(8);
    redir_arm = 1; redir_at = 3; redir_tgt = 9;
    run_to_done(200);
    chk("oor_reads_after_redirect", rd_after_redir, 0);
    bad = 0;
    foreach (delivered[i]) if (delivered[i] >= 3) bad++;
    chk("oor_stale_words", bad, 0);

    // Empty image never starts.
    apply_reset();
    begin_run(0);
    repeat (20) step();
    chk("zero_reads", issued.size(), 0);
    chk("zero_done_busy", {30'd0, s_busy, s_done}, 32'd0);

    // Reset with two words buffered, then a fresh load.
    apply_reset();
    ready_mode = 1;
    begin_run(8);
    for (int n = 0; n < 30 && m_q.size() != 2; n++) step();
    chk("mid_two_buffered", m_q.size(), 2);
    #2;
    RSTcount = 1'b1;
    model_reset();
    ret_v = 0;
    #1;
    chk("mid_reset_valid", {31'd0, instr_valid}, 32'd0);
    chk("mid_reset_busy", {31'd0, busy}, 32'd0);
    @(posedge clk);
    rel_reset = 1'b1;
    clear_logs();
    ready_mode = 0;
    run_to_done(200);
    chk("mid_restart_len", issued.size(), 8);
    if (issued.size() > 0) chk("mid_restart_addr0", issued[0], 0);
    chk_seq("mid_delivered", 0, 8);

    // Randomized runs with random backpressure and redirects.
    for (int r = 0; r < 8; r++) begin
      apply_reset();
      ready_mode = 2;
      begin_run($urandom_range(1, 12));
      redir_rand = 1;
      run_to_done(3000);
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

endmodule
`default_nettype wire
